ad1xx_loader: RTL
=================

# ad1xx_loader

Byte-stream program loader for the ad100 system. It receives a framed image over a valid/ready byte interface and writes the payload into the byte-addressed RAM. It holds the CPU in reset while loading and releases it once the frame has been validated. It writes the RAM that the CPU and benches later read back as little-endian words.

## Interface

Parameters:
- MEM_BYTES, 4096: RAM size in bytes; also the upper bound for the range check.
- ADDR_W, 12: width of mem_addr; must satisfy 2^ADDR_W >= MEM_BYTES.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte. A byte transfers when in_valid && in_ready at a rising clk edge.
- restart  input  1  single-cycle pulse that re-arms the loader from DONE or ERROR.
- mem_we  output  1  RAM byte write strobe.
- mem_addr  output  ADDR_W  RAM byte address.
- mem_wdata  output  8  RAM write byte.
- cpu_rst_n  output  1  active-low reset for the CPU core.
- done  output  1  frame loaded and checksum matched.
- error  output  1  frame rejected.

## Operation

Frame format, in order:
- 4 bytes: load address, little-endian (A).
- 4 bytes: byte count, little-endian (L).
- L bytes: payload.
- 1 byte: checksum, equal to the XOR of all preceding 8+L bytes.

State machine (state register and all outputs registered):
- HDR_ADDR: accept 4 bytes into A; go to HDR_LEN.
- HDR_LEN: accept 4 bytes into L. On the 4th byte, perform the range check: if A+L > MEM_BYTES (computed at 33 bits, so no wrap) go to ERROR. Otherwise go to DATA if L != 0, or to CSUM if L == 0.
- DATA: each accepted byte produces one write to address A+k, where k = 0..L-1. After the L-th byte go to CSUM.
- CSUM: accept 1 byte. If it equals the running XOR go to DONE, otherwise go to ERROR.
- DONE: done=1, cpu_rst_n=1, in_ready=0. On restart go to HDR_ADDR.
- ERROR: error=1, cpu_rst_n=0, in_ready=0. On restart go to HDR_ADDR.
- The running XOR clears on entry to HDR_ADDR. The byte counter and the A/L assembly registers also clear on entry to HDR_ADDR.
- restart has no effect in HDR_ADDR, HDR_LEN, DATA or CSUM.
- restart from DONE reasserts cpu_rst_n=0 and clears done, both in the next cycle.
- The RAM contents are not cleared by reset or restart.

## Timing

- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, done=0, error=0, state=HDR_ADDR.
- in_ready rises on the first clk edge after rst_n deasserts. It stays high in HDR_ADDR, HDR_LEN, DATA and CSUM.
- in_ready falls in the cycle after the byte that enters DONE or ERROR. No byte is accepted in that cycle.
- Write latency is 1 cycle. A payload byte accepted at edge N gives mem_we=1 with mem_addr and mem_wdata valid during cycle N+1. mem_we is a single-cycle pulse per byte.
- Throughput is one byte per cycle. Idle cycles (in_valid=0) change no state.
- done and cpu_rst_n rise together, 1 cycle after the checksum byte is accepted. This is always after the last mem_we pulse.
- error rises 1 cycle after the failing byte: the 4th length byte or the checksum byte.
- Asserting rst_n=0 mid-frame immediately forces all outputs to their reset values. Any pending mem_we is dropped, and the next frame starts at HDR_ADDR.

## Test plan

- Good frame: send 00 00 00 00 04 00 00 00 13 00 00 00 17. Required: writes 13,00,00,00 to addresses 0..3; done=1 and cpu_rst_n=1 one cycle after the last byte; RAM word 0 reads back as 0x00000013.
- Bad checksum: send the same frame with a trailer of 16. Required: error=1, cpu_rst_n stays 0, in_ready=0; the 4 RAM writes still occurred.
- Range error with MEM_BYTES=4096: header A=0x00000FFE, L=4. Required: error=1 one cycle after the 8th byte, no mem_we pulses, in_ready=0.
- Zero length: send 00 00 00 00 00 00 00 00 00. Required: no writes, done=1.
- Backpressure and gaps: send the good frame with in_valid deasserted for random gaps of 1–5 cycles. Required: results identical to the good-frame case and exactly 4 mem_we pulses.
- Reset and restart:
  - Pull rst_n low after 2 payload bytes. Required: all outputs go to reset values immediately.
  - Then send a full good frame. Required: done=1.
  - Then pulse restart. Required: done=0 and cpu_rst_n=0 on the next cycle, in_ready=1.

Source files
------------

// File: rtl/ad1xx_loader.sv
// Framed byte-stream program loader: parses addr/len header, writes payload to RAM,
// validates an XOR checksum and releases the CPU reset only on a good frame.
module ad1xx_loader #(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_e;

  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d, len_q, len_d, cnt_q, cnt_d;
  logic [7:0]  xor_q, xor_d;
  logic              in_ready_q, in_ready_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d, done_q, done_d, error_q, error_d;

  logic        acc;
  logic        hdr_last;
  logic [31:0] len_full;
  logic [32:0] end_addr;
  logic        range_bad;

  assign acc      = in_valid && in_ready_q;
  assign hdr_last = (cnt_q[1:0] == 2'd3);
  // Length as it will look once the 4th header byte lands; used for the same-cycle range check.
  assign len_full  = {in_data, len_q[23:0]};
  assign end_addr  = {1'b0, addr_q} + {1'b0, len_full};
  assign range_bad = end_addr > 33'(MEM_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_ADDR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ADDR: if (acc && hdr_last) state_d = S_LEN;
      S_LEN:  if (acc && hdr_last)
                state_d = range_bad ? S_ERR : ((len_full == 32'd0) ? S_CSUM : S_DATA);
      S_DATA: if (acc && (cnt_q == len_q - 32'd1)) state_d = S_CSUM;
      S_CSUM: if (acc) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      S_DONE, S_ERR: if (restart) state_d = S_ADDR;
      default: state_d = S_ADDR;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    xor_d       = acc ? (xor_q ^ in_data) : xor_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_ADDR: if (acc) begin
        addr_d[{cnt_q[1:0], 3'b000} +: 8] = in_data;
        cnt_d = hdr_last ? 32'd0 : cnt_q + 32'd1;
      end
      S_LEN: if (acc) begin
        len_d[{cnt_q[1:0], 3'b000} +: 8] = in_data;
        cnt_d = hdr_last ? 32'd0 : cnt_q + 32'd1;
      end
      S_DATA: if (acc) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = ADDR_W'(addr_q + cnt_q);
        mem_wdata_d = in_data;
        cnt_d       = cnt_q + 32'd1;
      end
      S_DONE, S_ERR: if (restart) begin
        addr_d = '0;
        len_d  = '0;
        cnt_d  = '0;
        xor_d  = '0;
      end
      default: ;
    endcase
    in_ready_d  = state_d inside {S_ADDR, S_LEN, S_DATA, S_CSUM};
    done_d      = (state_d == S_DONE);
    cpu_rst_n_d = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      xor_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      xor_q       <= xor_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
